// File: rtl/calc_pkg.sv
// Shared calculator definitions.
// Holds the ALU result width, the BCD digit geometry used by the display
// path, and the state encoding of the result-to-BCD converter.
package calc_pkg;

  localparam int RESULT_W    = 17;
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 6;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit correction for double dabble.
// Adds 3 to a digit of 5 or more, so that the following left shift carries
// correctly into the next decimal digit.
// Ports:
//   digit    - current 4-bit scratch digit
//   adjusted - digit after the add-3 correction
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/alu_result_bcd.sv
// ALU result to sign + packed BCD converter for the display path.
// Takes one input bit per clock (shift-add-3); a conversion lasts W cycles
// of busy and finishes with a one-cycle done pulse that updates bcd/neg.
// Ports:
//   clk         - system clock, rising edge
//   clear       - synchronous active-high reset, overrides everything
//   start       - request conversion of result_in, honoured only when idle
//   result_in   - ALU result word
//   signed_mode - 1: result_in is two's complement, 0: unsigned
//   busy        - conversion in progress
//   done        - one-cycle pulse when bcd/neg are updated
//   neg         - sign of the last converted value
//   bcd         - packed BCD, most significant digit on top
module alu_result_bcd
  import calc_pkg::*;
#(
  parameter int W      = RESULT_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          start,
  input  logic [W-1:0]                  result_in,
  input  logic                          signed_mode,
  output logic                          busy,
  output logic                          done,
  output logic                          neg,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(W + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       bin;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adj;
  logic               neg_pending;
  logic               is_neg;
  logic [W-1:0]       mag;
  logic [BCD_W+W-1:0] shifted;

  // Negating the most negative value wraps back onto itself, which is the
  // correct magnitude when read as W-bit unsigned (0x10000 -> 65536).
  assign is_neg = signed_mode & result_in[W-1];
  assign mag    = is_neg ? (~result_in + 1'b1) : result_in;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Correct every digit first, then move one binary bit into the scratch.
  assign shifted = {adj, bin} << 1;

  assign busy = (state == ST_CONVERT);

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bin         <= '0;
      scratch     <= '0;
      neg_pending <= 1'b0;
      done        <= 1'b0;
      neg         <= 1'b0;
      bcd         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin         <= mag;
            neg_pending <= is_neg;
            scratch     <= '0;
            cnt         <= CNT_W'(W);
            state       <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          {scratch, bin} <= shifted;
          cnt            <= cnt - CNT_W'(1);
          // Last bit shifted in: publish the result and return to idle so
          // a new start is accepted in the done cycle.
          if (cnt == CNT_W'(1)) begin
            bcd   <= shifted[BCD_W+W-1:W];
            neg   <= neg_pending;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_bcd.sv
// Testbench for alu_result_bcd: table vectors, hand-written multi-cycle
// sequences and randomized conversions against a decimal reference model.
module tb_alu_result_bcd;

  logic        clk;
  logic        clear;
  logic        start;
  logic [16:0] result_in;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic        neg;
  logic [23:0] bcd;

  int tests  = 0;
  int failed = 0;

  alu_result_bcd dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .result_in   (result_in),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .neg         (neg),
    .bcd         (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] val;
    logic        sm;
    logic        exp_neg;
    logic [23:0] exp_bcd;
  } vec_t;

  vec_t vecs[8];

  // Reference: sign/magnitude by plain arithmetic, digits by repeated /10.
  function automatic logic [24:0] model(input logic [16:0] v, input logic sm);
    int unsigned m;
    logic        ng;
    logic [23:0] b;
    ng = sm && v[16];
    m  = ng ? (32'd131072 - 32'(v)) : 32'(v);
    b  = '0;
    for (int d = 0; d < 6; d++) begin
      b[d*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {ng, b};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge (cycle 0). Returns the cycle of the
  // done pulse (-1 if none within 40 cycles) and how many cycles broke the
  // busy profile (busy high before done, low on the done cycle).
  task automatic convert(input logic [16:0] v, input logic sm,
                         output logic n, output logic [23:0] b,
                         output int dcyc, output int busy_bad);
    start = 1'b1; result_in = v; signed_mode = sm;
    dcyc = -1; busy_bad = 0; n = 1'bx; b = 'x;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      result_in = 17'($urandom);
      signed_mode = 1'($urandom);
      if (done) begin
        dcyc = c; n = neg; b = bcd;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
    end
  endtask

  initial begin : main
    logic        n;
    logic [23:0] b;
    logic [24:0] m;
    int          dc, bb, ndone, first_dc, second_dc, busy_seen;

    vecs[0] = '{17'd12345,  1'b0, 1'b0, 24'h012345};
    vecs[1] = '{17'h1FFFF,  1'b1, 1'b1, 24'h000001};
    vecs[2] = '{17'h10000,  1'b1, 1'b1, 24'h065536};
    vecs[3] = '{17'h1FFFF,  1'b0, 1'b0, 24'h131071};
    vecs[4] = '{17'd0,      1'b1, 1'b0, 24'h000000};
    vecs[5] = '{17'd99999,  1'b0, 1'b0, 24'h099999};
    vecs[6] = '{17'h0FFFF,  1'b1, 1'b0, 24'h065535};
    vecs[7] = '{17'h1CFC7,  1'b1, 1'b1, 24'h012345};

    clear = 1'b1; start = 1'b0; result_in = '0; signed_mode = 1'b0;
    repeat (2) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_neg",  32'(neg),  32'd0);
    check("reset_bcd",  32'(bcd),  32'd0);
    clear = 1'b0;
    tick();

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].val, vecs[i].sm, n, b, dc, bb);
      check($sformatf("vec%0d_done_cycle", i), 32'(dc), 32'd18);
      check($sformatf("vec%0d_busy", i), 32'(bb), 32'd0);
      check($sformatf("vec%0d_neg", i), 32'(n), 32'(vecs[i].exp_neg));
      check($sformatf("vec%0d_bcd", i), 32'(b), 32'(vecs[i].exp_bcd));
      tick();
      check($sformatf("vec%0d_pulse", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_hold", i), 32'(bcd), 32'(vecs[i].exp_bcd));
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    start = 1'b1; result_in = 17'd12345; signed_mode = 1'b0;
    ndone = 0; first_dc = -1; second_dc = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      if (c == 5) begin start = 1'b1; result_in = 17'd54321; end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_dc = c;
          check("bb_first_bcd", 32'(bcd), 32'h012345);
        end else begin
          second_dc = c;
          check("bb_second_bcd", 32'(bcd), 32'h054321);
        end
      end
      if (c == 18) begin start = 1'b1; result_in = 17'd54321; signed_mode = 1'b0; end
      if (c == 25) check("bb_hold_between", 32'(bcd), 32'h012345);
    end
    check("bb_ndone", 32'(ndone), 32'd2);
    check("bb_first_cycle", 32'(first_dc), 32'd18);
    check("bb_second_cycle", 32'(second_dc), 32'd36);

    // Leave neg=1 and a nonzero bcd so the clear below is observable.
    convert(17'h1FFFF, 1'b1, n, b, dc, bb);
    check("pre_clear_neg", 32'(n), 32'd1);
    tick();

    // Clear mid-conversion aborts with no done.
    start = 1'b1; result_in = 17'd99999; signed_mode = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      if (done) ndone++;
      if (c == 8) clear = 1'b1;
    end
    tick();
    clear = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd",  32'(bcd),  32'd0);
    check("abort_neg",  32'(neg),  32'd0);
    for (int c = 0; c < 25; c++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    convert(17'd7, 1'b0, n, b, dc, bb);
    check("after_abort_cycle", 32'(dc), 32'd18);
    check("after_abort_bcd", 32'(b), 32'h000007);
    tick();

    // Clear and start on the same edge: clear wins.
    clear = 1'b1; start = 1'b1; result_in = 17'd5; signed_mode = 1'b0;
    tick();
    clear = 1'b0; start = 1'b0;
    ndone = 0; busy_seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (done) ndone++;
      if (busy) busy_seen++;
      tick();
    end
    check("clr_start_busy", 32'(busy_seen), 32'd0);
    check("clr_start_done", 32'(ndone), 32'd0);
    check("clr_start_bcd", 32'(bcd), 32'd0);

    // Randomized conversions against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [16:0] v;
      logic        sm;
      v  = 17'($urandom);
      sm = 1'($urandom);
      if (i % 10 == 0) v = (i % 20 == 0) ? 17'h10000 : 17'h00000;
      m = model(v, sm);
      convert(v, sm, n, b, dc, bb);
      check($sformatf("rnd%0d_cycle", i), 32'(dc), 32'd18);
      check($sformatf("rnd%0d_result v=%0h sm=%0b", i, v, sm), 32'({n, b}), 32'(m));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
